// File: rtl/risci_mem_pkg.sv
// Shared types and constants for the memory arbiter.
//   state_e : arbiter FSM states (IDLE -> ACCESS -> RESP)
//   port_e  : which requester owns the current access
//   LEN_*   : RAM access length encodings
//   fwd_len : maps a requested length onto the length driven to the RAM
package risci_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;
  localparam logic [1:0] LEN_RSVD = 2'd3;

  // The reserved length encoding is treated as a full word.
  function automatic logic [1:0] fwd_len(input logic [1:0] len);
    return (len == LEN_RSVD) ? LEN_WORD : len;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter for the instruction port.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, clears count
//   inc   : increment by one, saturating at all-ones
//   clr   : clear to zero (wins over inc)
//   count : current count
module arb_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port RAM.
// Every access is IDLE (decide) -> ACCESS (RAM strobe) -> RESP (ack + data).
// Data wins by default; the fetch port is forced through after MAX_WAIT
// consecutive losses.
//   clk, rst            : clock and asynchronous active-low reset
//   hlt                 : gates new grants only; an access in flight completes
//   i_req/i_addr        : fetch request; i_ack/i_rdata complete it
//   d_req/d_we/d_addr/
//   d_wdata/d_len       : data request; d_ack/d_rdata complete it
//   m_*                 : RAM side; m_rdata returns one cycle after m_re
//   busy                : high whenever the FSM is not idle
module mem_arbiter
  import risci_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_len,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_re,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_len,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_e            state_q, state_d;
  port_e             port_q;
  logic              is_write_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [1:0]        m_len_q;
  logic              grant_i;
  logic              grant_d;
  logic [3:0]        wait_cnt;

  // Grant decision happens only in IDLE; ACCESS and RESP always advance,
  // so a dropped request or a late hlt cannot cut an access short.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hlt && (i_req || d_req)) begin
          if (i_req && (!d_req || (wait_cnt >= MAX_WAIT_C))) begin
            grant_i = 1'b1;
          end else begin
            grant_d = 1'b1;
          end
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Losing to data only counts as a wait when a fetch was actually pending.
  arb_wait_counter #(
    .CNT_W (4)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (grant_d && i_req),
    .clr   (grant_i),
    .count (wait_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      port_q     <= PORT_I;
      is_write_q <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_len_q    <= LEN_BYTE;
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        port_q     <= PORT_I;
        is_write_q <= 1'b0;
        m_addr_q   <= i_addr;
        m_wdata_q  <= '0;
        m_len_q    <= LEN_WORD;
      end else if (grant_d) begin
        port_q     <= PORT_D;
        is_write_q <= d_we;
        m_addr_q   <= d_addr;
        m_wdata_q  <= d_wdata;
        m_len_q    <= fwd_len(d_len);
      end
    end
  end

  // Strobes, acks and read data are decoded from registered state, so they
  // drop to zero the moment reset asserts.
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_len   = m_len_q;
  assign m_re    = (state_q == ACCESS) && !is_write_q;
  assign m_we    = (state_q == ACCESS) &&  is_write_q;
  assign i_ack   = (state_q == RESP) && (port_q == PORT_I);
  assign d_ack   = (state_q == RESP) && (port_q == PORT_D);
  assign i_rdata = (i_ack && !is_write_q) ? m_rdata : '0;
  assign d_rdata = (d_ack && !is_write_q) ? m_rdata : '0;
  assign busy    = (state_q != IDLE);

endmodule
